axi_i2c: RTL and testbench
==========================

// Module: axi_i2c
// PURPOSE
//  AXI4-Lite slave exposing an I2C-controller register file. The I2C bus is emulated internally.
//  A byte written to TX while enabled runs a fixed-latency transfer against a built-in model slave.
//  The model slave returns TX+1 in RX. Used as an SoC peripheral stand-in for firmware and
//  interconnect bring-up; there are no external SCL/SDA pins.
// PARAMETERS
//  SLAVE_ADDR   7'h50  7-bit address the emulated slave acknowledges
//  XFER_CYCLES  2      clock cycles from transfer start to RX/DONE update (>=1)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  resetn         in   1   asynchronous, active-low reset
//  s_axi_awaddr   in   12  write address (byte); only [4:2] decoded
//  s_axi_awvalid  in   1   write address valid
//  s_axi_awready  out  1   write address ready
//  s_axi_wdata    in   32  write data
//  s_axi_wstrb    in   4   byte-lane enables
//  s_axi_wvalid   in   1   write data valid
//  s_axi_wready   out  1   write data ready
//  s_axi_bresp    out  2   write response, always 2'b00
//  s_axi_bvalid   out  1   write response valid
//  s_axi_bready   in   1   write response ready
//  s_axi_araddr   in   12  read address
//  s_axi_arvalid  in   1   read address valid
//  s_axi_arready  out  1   read address ready
//  s_axi_rdata    out  32  read data
//  s_axi_rresp    out  2   read response, always 2'b00
//  s_axi_rvalid   out  1   read data valid
//  s_axi_rready   in   1   read data ready
// BEHAVIOUR
//  Reset: all readies/valids 0, rdata 0, resp 0; CTRL=0, ADDR=0, TX=0, RX=0, STATUS=0, FSM IDLE.
//  Register map (unused bits read 0; wstrb honoured per byte):
//   0x000 CTRL   RW  [0] EN
//   0x004 ADDR   RW  [6:0] target address
//   0x008 TX     RW  [7:0] data; write starts a transfer
//   0x00C RX     RO  [7:0] last received byte
//   0x010 STATUS RO  [0] BUSY, [1] DONE, [2] NACK
//   Other offsets: reads return 0, writes are ignored, response is OKAY.
//  Write channel:
//   - awready and wready are registered and asserted together for exactly one cycle.
//   - They assert when awvalid && wvalid && !bvalid.
//   - The register update occurs on the handshake edge.
//   - bvalid rises the next cycle and holds until bready.
//   - No new write is accepted while bvalid=1.
//  Read channel:
//   - arready is a one-cycle pulse when arvalid && !rvalid.
//   - rdata is captured on the handshake edge.
//   - rvalid rises the next cycle with rdata already stable; it holds until rready.
//   - On a simultaneous read/write, the read samples pre-write register values.
//  Transfer FSM: IDLE -> XFER -> IDLE.
//   - Start condition: a TX write with lane0 set, EN=1 and BUSY=0.
//   - On start: BUSY=1, DONE=0, NACK=0, counter=XFER_CYCLES-1.
//   - XFER decrements the counter each cycle. At 0 the FSM returns to IDLE and sets BUSY=0, DONE=1.
//   - If ADDR==SLAVE_ADDR: RX = (TX+1) mod 256 (0xFF -> 0x00). Otherwise NACK=1 and RX is unchanged.
//   - TX write with EN=0 stores TX only; no transfer, STATUS unchanged.
//   - TX write while BUSY is ignored entirely; the response is still OKAY.
//   - Clearing EN mid-transfer does not abort the transfer.
//   - CTRL/ADDR writes during BUSY update the register; the ACK/NACK check uses ADDR at completion.
//   - Asserting resetn low mid-transfer returns everything to reset values immediately.
//  Latency: with XFER_CYCLES=2, RX is valid 2 cycles after the TX write handshake edge.
// STRUCTURE
//  Package axi_i2c_pkg:
//   - register offset localparams (REG_CTRL..REG_STATUS);
//   - STATUS bit indices;
//   - FSM state enum {ST_IDLE, ST_XFER}.
//  Sub-module i2c_loopback_model: transfer FSM, counter, address compare, TX+1 generation.
//   Inputs: start, tx, addr. Outputs: busy, done, nack, rx, rx_we.
//  Top level holds the AXI-Lite handshakes and the register file.
// TESTING
//  - CTRL=1, ADDR=0x50, TX=0xA5, wait 50 ns, read 0x00C -> 0x000000A6; STATUS -> 0x2.
//  - ADDR=0x50, TX=0xFF with EN=1 -> RX=0x00, DONE=1, NACK=0.
//  - ADDR=0x51, TX=0x10 with EN=1 -> STATUS=0x6 (DONE|NACK), RX keeps its previous value.
//  - CTRL=0, TX=0x33 -> STATUS=0, RX unchanged; read 0x008 -> 0x33.
//  - Read CTRL/ADDR back -> written values masked to 1/7 bits.
//    Write 0xABC, read 0x100 -> 0, OKAY responses.
//  - Two TX writes within XFER_CYCLES -> second ignored, RX=first+1.
//    resetn pulse while BUSY -> all registers 0.

Source files
------------

// File: rtl/axi_i2c_pkg.sv
// Shared register offsets, status bit positions and transfer FSM states for the
// AXI-Lite I2C controller stand-in.
package axi_i2c_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_TX     = 3'd2;
    localparam logic [2:0] REG_RX     = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_NACK = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/i2c_loopback_model.sv
// Emulated I2C transfer: fixed-latency down-counter, address check at completion,
// and a model slave that answers with tx+1.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | no transfer in flight, waiting for start
//  ST_XFER | counting down; completes when counter hits 0
module i2c_loopback_model #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         XFER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic [6:0] addr,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rx,
    output logic       rx_we
);
    import axi_i2c_pkg::*;

    localparam int              CW       = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XFER_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          tc;
    logic          ack;

    assign tc  = (cnt == '0);
    assign ack = (addr == SLAVE_ADDR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_XFER;
            ST_XFER: if (tc)    state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == ST_XFER);
        rx_we = busy && tc && ack;
        rx    = tx + 8'd1;
    end

    // The address is compared at completion, so ADDR writes mid-transfer take effect.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            done <= 1'b0;
            nack <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                cnt  <= CNT_LOAD;
                done <= 1'b0;
                nack <= 1'b0;
            end
        end else if (tc) begin
            done <= 1'b1;
            nack <= !ack;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_i2c.sv
// AXI4-Lite slave holding the I2C controller register file; transfers run against
// an internal loopback model, there are no bus pins.
module axi_i2c #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         XFER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [11:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);
    import axi_i2c_pkg::*;

    logic        wr_rdy;
    logic        wr_hs;
    logic        rd_hs;
    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;
    logic [31:0] rd_mux;
    logic        ctrl_en;
    logic [6:0]  addr_reg;
    logic [7:0]  tx_reg;
    logic [7:0]  rx_reg;
    logic        tx_wr;
    logic        start;
    logic        busy;
    logic        done;
    logic        nack;
    logic [7:0]  rx_nxt;
    logic        rx_we;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_awaddr[11:5], s_axi_awaddr[1:0], s_axi_araddr[11:5],
                           s_axi_araddr[1:0], s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    assign s_axi_awready = wr_rdy;
    assign s_axi_wready  = wr_rdy;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;

    assign wr_idx = s_axi_awaddr[4:2];
    assign rd_idx = s_axi_araddr[4:2];
    assign wr_hs  = wr_rdy && s_axi_awvalid && s_axi_wvalid;
    assign rd_hs  = s_axi_arready && s_axi_arvalid;
    // A TX write during a transfer is dropped entirely, data included.
    assign tx_wr  = wr_hs && (wr_idx == REG_TX) && s_axi_wstrb[0] && !busy;
    assign start  = tx_wr && ctrl_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_rdy       <= 1'b0;
            s_axi_bvalid <= 1'b0;
        end else begin
            wr_rdy <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !wr_rdy;
            if (wr_hs)             s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_CTRL:   rd_mux[0]   = ctrl_en;
            REG_ADDR:   rd_mux[6:0] = addr_reg;
            REG_TX:     rd_mux[7:0] = tx_reg;
            REG_RX:     rd_mux[7:0] = rx_reg;
            REG_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done;
                rd_mux[STAT_NACK] = nack;
            end
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (rd_hs) begin
                s_axi_rdata  <= rd_mux;
                s_axi_rvalid <= 1'b1;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_en  <= 1'b0;
            addr_reg <= '0;
            tx_reg   <= '0;
            rx_reg   <= '0;
        end else begin
            if (wr_hs && s_axi_wstrb[0]) begin
                if (wr_idx == REG_CTRL) ctrl_en  <= s_axi_wdata[0];
                if (wr_idx == REG_ADDR) addr_reg <= s_axi_wdata[6:0];
            end
            if (tx_wr) tx_reg <= s_axi_wdata[7:0];
            if (rx_we) rx_reg <= rx_nxt;
        end
    end

    i2c_loopback_model #(
        .SLAVE_ADDR  (SLAVE_ADDR),
        .XFER_CYCLES (XFER_CYCLES)
    ) u_model (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .tx     (tx_reg),
        .addr   (addr_reg),
        .busy   (busy),
        .done   (done),
        .nack   (nack),
        .rx     (rx_nxt),
        .rx_we  (rx_we)
    );

endmodule

// File: tb/tb_axi_i2c.sv
// Scoreboard bench for axi_i2c: stimulus queues expected responses, a monitor
// compares them when the DUT presents R/B beats.
module tb_axi_i2c;

    localparam int XC = 6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [11:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_r[$];
    string       exp_n[$];
    logic [1:0]  exp_b[$];

    always #5 clk = ~clk;

    axi_i2c #(.SLAVE_ADDR(7'h50), .XFER_CYCLES(XC)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        exp_b.push_back(2'b00);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(s_axi_awready && s_axi_wready) && n < 50);
        if (!(s_axi_awready && s_axi_wready)) begin
            timeout("aw_w_ready");
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_bvalid) begin timeout("bvalid"); return; end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input string name, input logic [11:0] a, input logic [31:0] e);
        int n;
        exp_r.push_back(e);
        exp_n.push_back(name);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
        if (!s_axi_arready) begin timeout("arready"); s_axi_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_rvalid) begin timeout("rvalid"); return; end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: rdata 0x%08h with no pending read", s_axi_rdata);
                end else begin
                    check(exp_n.pop_front(), s_axi_rdata, exp_r.pop_front());
                    check("rresp", {30'd0, s_axi_rresp}, 32'd0);
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: bresp %0d with no pending write", s_axi_bresp);
                end else begin
                    check("bresp", {30'd0, s_axi_bresp}, {30'd0, exp_b.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
        check("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // TX write with EN=0 stores the byte but starts nothing
        axi_write(12'h008, 32'h0000_0033, 4'hF);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("en0_status", 12'h010, 32'h0);
        axi_read("en0_rx",     12'h00C, 32'h0);
        axi_read("en0_tx",     12'h008, 32'h33);

        // Field masking and byte strobes
        axi_write(12'h000, 32'hFFFF_FFFF, 4'hF);
        axi_read("ctrl_mask", 12'h000, 32'h1);
        axi_write(12'h004, 32'hFFFF_FFFF, 4'hF);
        axi_read("addr_mask", 12'h004, 32'h7F);
        axi_write(12'h004, 32'h0000_0050, 4'hE);
        axi_read("addr_strb", 12'h004, 32'h7F);
        axi_write(12'h004, 32'h0000_0050, 4'h1);

        // Acked transfer
        axi_write(12'h008, 32'h0000_00A5, 4'hF);
        axi_read("a5_busy",   12'h010, 32'h1);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("a5_rx",     12'h00C, 32'hA6);
        axi_read("a5_status", 12'h010, 32'h2);

        // Wrap 0xFF -> 0x00; start clears DONE
        axi_write(12'h008, 32'h0000_00FF, 4'hF);
        axi_read("ff_busy",   12'h010, 32'h1);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("ff_rx",     12'h00C, 32'h0);
        axi_read("ff_status", 12'h010, 32'h2);

        // Wrong address -> NACK, RX held
        axi_write(12'h004, 32'h0000_0051, 4'hF);
        axi_write(12'h008, 32'h0000_0010, 4'hF);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("nack_status", 12'h010, 32'h6);
        axi_read("nack_rx",     12'h00C, 32'h0);

        // Second TX write while busy is dropped; start clears DONE and NACK
        axi_write(12'h004, 32'h0000_0050, 4'hF);
        axi_write(12'h008, 32'h0000_0020, 4'hF);
        axi_read("dbl_busy",  12'h010, 32'h1);
        axi_write(12'h008, 32'h0000_0040, 4'hF);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("dbl_rx",     12'h00C, 32'h21);
        axi_read("dbl_tx",     12'h008, 32'h20);
        axi_read("dbl_status", 12'h010, 32'h2);

        // ADDR changed mid-transfer is used at completion; clearing EN does not abort
        axi_write(12'h008, 32'h0000_0030, 4'hF);
        axi_write(12'h004, 32'h0000_0051, 4'hF);
        axi_write(12'h000, 32'h0000_0000, 4'hF);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("mid_status", 12'h010, 32'h6);
        axi_read("mid_rx",     12'h00C, 32'h21);
        axi_read("mid_ctrl",   12'h000, 32'h0);

        // Unmapped offsets: 0xABC decodes to slot 7, 0x100 aliases CTRL (currently 0)
        axi_write(12'hABC, 32'hFFFF_FFFF, 4'hF);
        axi_read("unmap_100", 12'h100, 32'h0);
        axi_read("unmap_014", 12'h014, 32'h0);
        axi_read("unmap_01c", 12'h01C, 32'h0);
        axi_read("unmap_addr", 12'h004, 32'h51);

        // TX write without lane 0 starts nothing and leaves TX
        axi_write(12'h000, 32'h0000_0001, 4'hF);
        axi_write(12'h004, 32'h0000_0050, 4'hF);
        axi_write(12'h008, 32'h0000_0077, 4'h2);
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("lane_tx",     12'h008, 32'h30);
        axi_read("lane_status", 12'h010, 32'h6);

        // Reset in the middle of a transfer
        axi_write(12'h008, 32'h0000_0055, 4'hF);
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rstmid_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        resetn = 1'b1;
        repeat (XC + 4) @(posedge clk); #1;
        axi_read("rstmid_ctrl",   12'h000, 32'h0);
        axi_read("rstmid_addr",   12'h004, 32'h0);
        axi_read("rstmid_tx",     12'h008, 32'h0);
        axi_read("rstmid_rx",     12'h00C, 32'h0);
        axi_read("rstmid_status", 12'h010, 32'h0);

        repeat (4) @(posedge clk); #1;
        check("queues_drained", exp_r.size() + exp_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
